// File: rtl/rollback_arbiter_pkg.sv
// Shared types for the rollback arbiter: thread/PC scalars, trap causes and the merged
// rollback request record.
package rollback_arbiter_pkg;

  localparam int unsigned THREADS_PER_CORE = 4;
  localparam int unsigned ThreadIdxWidth   = $clog2(THREADS_PER_CORE);
  localparam int unsigned SquashCntWidth   = 3;

  typedef logic [ThreadIdxWidth-1:0] local_thread_idx_t;
  typedef logic [31:0]               scalar_t;

  typedef enum logic [3:0] {
    TRAP_NONE           = 4'd0,
    TRAP_ILLEGAL_INST   = 4'd1,
    TRAP_PRIVILEGED_OP  = 4'd2,
    TRAP_DATA_ALIGNMENT = 4'd3,
    TRAP_SYSCALL        = 4'd4
  } trap_cause_t;

  typedef struct packed {
    logic              valid;
    local_thread_idx_t thread;
    scalar_t           pc;
    logic              trap;
    trap_cause_t       cause;
  } rollback_req_t;

  // A privileged-op fault overrides a branch redirect from the same instruction.
  function automatic rollback_req_t ix_to_req(input logic              valid,
                                              input logic              rollback_en,
                                              input logic              priv_fault,
                                              input local_thread_idx_t thread,
                                              input scalar_t           rollback_pc,
                                              input scalar_t           trap_handler);
    rollback_req_t req;
    req.valid  = valid && (rollback_en || priv_fault);
    req.thread = thread;
    req.trap   = priv_fault;
    req.pc     = priv_fault ? trap_handler : rollback_pc;
    req.cause  = priv_fault ? TRAP_PRIVILEGED_OP : TRAP_NONE;
    return req;
  endfunction

endpackage

// File: rtl/rollback_arbiter_if.sv
// Bundles the integer-execute, dcache data-stage and writeback rollback signals.
interface rollback_arbiter_if;
  import rollback_arbiter_pkg::*;

  logic              ix_instruction_valid;
  local_thread_idx_t ix_thread_idx;
  logic              ix_rollback_en;
  scalar_t           ix_rollback_pc;
  logic              ix_privileged_op_fault;
  logic              dd_rollback_en;
  scalar_t           dd_rollback_pc;
  local_thread_idx_t dd_thread_idx;
  scalar_t           cr_trap_handler;

  logic              wb_rollback_en;
  local_thread_idx_t wb_rollback_thread_idx;
  scalar_t           wb_rollback_pc;
  logic              wb_trap;
  trap_cause_t       wb_trap_cause;
  logic              wb_perf_squashed;
  logic              wb_overflow;

  modport master (
    output ix_instruction_valid, ix_thread_idx, ix_rollback_en, ix_rollback_pc,
           ix_privileged_op_fault, dd_rollback_en, dd_rollback_pc, dd_thread_idx,
           cr_trap_handler,
    input  wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc, wb_trap, wb_trap_cause,
           wb_perf_squashed, wb_overflow
  );

  modport slave (
    input  ix_instruction_valid, ix_thread_idx, ix_rollback_en, ix_rollback_pc,
           ix_privileged_op_fault, dd_rollback_en, dd_rollback_pc, dd_thread_idx,
           cr_trap_handler,
    output wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc, wb_trap, wb_trap_cause,
           wb_perf_squashed, wb_overflow
  );

endinterface

// File: rtl/rollback_squash_counter.sv
// Per-thread squash window: loads on a rollback, counts down to zero, flags when idle.
module rollback_squash_counter #(
  parameter int unsigned Width   = 3,
  parameter int unsigned LoadVal = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Width'(LoadVal);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rollback_arbiter.sv
// Merges dcache data-stage and integer-execute rollbacks into one registered flush bus,
// squashing younger same-thread requests and holding one deferred integer request.
module rollback_arbiter
  import rollback_arbiter_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  rollback_arbiter_if.slave bus
);

  rollback_req_t ix_req, dd_req, win;
  rollback_req_t pend_d, pend_q;
  rollback_req_t wb_d, wb_q;
  logic          perf_d, perf_q;
  logic          ovf_d, ovf_q;
  logic          ix_squashed, pend_squashed, ix_won, ix_loses;

  logic [THREADS_PER_CORE-1:0] cnt_zero;
  logic [THREADS_PER_CORE-1:0] cnt_load;

  assign ix_req = ix_to_req(bus.ix_instruction_valid, bus.ix_rollback_en,
                            bus.ix_privileged_op_fault, bus.ix_thread_idx,
                            bus.ix_rollback_pc, bus.cr_trap_handler);

  always_comb begin
    dd_req        = '0;
    dd_req.valid  = bus.dd_rollback_en;
    dd_req.thread = bus.dd_thread_idx;
    dd_req.pc     = bus.dd_rollback_pc;
    dd_req.trap   = 1'b0;
    dd_req.cause  = TRAP_NONE;
  end

  for (genvar t = 0; t < THREADS_PER_CORE; t++) begin : g_squash
    rollback_squash_counter #(
      .Width   (SquashCntWidth),
      .LoadVal (SQUASH_CYCLES)
    ) u_squash_counter (
      .clk_i   (clk),
      .reset_i (reset),
      .load_i  (cnt_load[t]),
      .zero_o  (cnt_zero[t])
    );
  end

  always_comb begin
    win           = '0;
    ix_won        = 1'b0;
    cnt_load      = '0;
    pend_d        = pend_q;
    ovf_d         = ovf_q;
    ix_squashed   = ix_req.valid && !cnt_zero[ix_req.thread];
    pend_squashed = pend_q.valid && !cnt_zero[pend_q.thread];

    // Oldest first: dcache data stage, then the deferred entry, then integer execute.
    if (dd_req.valid) begin
      win = dd_req;
    end else if (pend_q.valid && !pend_squashed) begin
      win = pend_q;
    end else if (ix_req.valid && !ix_squashed) begin
      win    = ix_req;
      ix_won = 1'b1;
    end

    if (win.valid) begin
      cnt_load[win.thread] = 1'b1;
    end

    // Pending leaves when issued, squashed, or overtaken by an older same-thread dd flush.
    if (pend_q.valid) begin
      if (pend_squashed || !dd_req.valid || (dd_req.thread == pend_q.thread)) begin
        pend_d.valid = 1'b0;
      end
    end

    // A same-thread loser is younger than the winner and is flushed by it anyway.
    ix_loses = ix_req.valid && !ix_squashed && !ix_won && (win.thread != ix_req.thread);
    if (ix_loses) begin
      if (!pend_d.valid) begin
        pend_d = ix_req;
      end else begin
        ovf_d = 1'b1;
      end
    end

    perf_d = ix_squashed || pend_squashed;
    wb_d   = win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      wb_q   <= '0;
      perf_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      wb_q   <= wb_d;
      perf_q <= perf_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.wb_rollback_en         = wb_q.valid;
  assign bus.wb_rollback_thread_idx = wb_q.thread;
  assign bus.wb_rollback_pc         = wb_q.pc;
  assign bus.wb_trap                = wb_q.trap;
  assign bus.wb_trap_cause          = wb_q.cause;
  assign bus.wb_perf_squashed       = perf_q;
  assign bus.wb_overflow            = ovf_q;

endmodule

// File: tb/tb_rollback_arbiter.sv
// Directed bench for rollback_arbiter: issue latency, trap override, squash window,
// priority/deferral, same-thread drop, overflow and reset.
module tb_rollback_arbiter;
  import rollback_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  rollback_arbiter_if bus ();

  rollback_arbiter #(
    .SQUASH_CYCLES (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ix_instruction_valid   = 1'b0;
    bus.ix_thread_idx          = '0;
    bus.ix_rollback_en         = 1'b0;
    bus.ix_rollback_pc         = '0;
    bus.ix_privileged_op_fault = 1'b0;
    bus.dd_rollback_en         = 1'b0;
    bus.dd_rollback_pc         = '0;
    bus.dd_thread_idx          = '0;
    bus.cr_trap_handler        = '0;
  endtask

  task automatic drive_ix(input int thread, input logic [31:0] pc, input logic fault);
    bus.ix_instruction_valid   = 1'b1;
    bus.ix_thread_idx          = local_thread_idx_t'(thread);
    bus.ix_rollback_en         = 1'b1;
    bus.ix_rollback_pc         = pc;
    bus.ix_privileged_op_fault = fault;
  endtask

  task automatic drive_dd(input int thread, input logic [31:0] pc);
    bus.dd_rollback_en = 1'b1;
    bus.dd_thread_idx  = local_thread_idx_t'(thread);
    bus.dd_rollback_pc = pc;
  endtask

  task automatic settle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    check_eq("rst_en",    32'(bus.wb_rollback_en), 32'd0);
    check_eq("rst_pc",    bus.wb_rollback_pc, 32'd0);
    check_eq("rst_trap",  32'(bus.wb_trap), 32'd0);
    check_eq("rst_cause", 32'(bus.wb_trap_cause), 32'd0);
    check_eq("rst_perf",  32'(bus.wb_perf_squashed), 32'd0);
    check_eq("rst_ovf",   32'(bus.wb_overflow), 32'd0);
    settle(1);
    check_eq("idle_en",   32'(bus.wb_rollback_en), 32'd0);

    // Plain integer rollback, one-cycle latency.
    drive_ix(0, 32'h8374_0350, 1'b0);
    step();
    check_eq("ix_en",     32'(bus.wb_rollback_en), 32'd1);
    check_eq("ix_thread", 32'(bus.wb_rollback_thread_idx), 32'd0);
    check_eq("ix_pc",     bus.wb_rollback_pc, 32'h8374_0350);
    check_eq("ix_trap",   32'(bus.wb_trap), 32'd0);
    settle(3);

    // Fault overrides the simultaneous redirect.
    drive_ix(1, 32'hdead_beef, 1'b1);
    bus.cr_trap_handler = 32'h1000;
    step();
    check_eq("flt_en",     32'(bus.wb_rollback_en), 32'd1);
    check_eq("flt_thread", 32'(bus.wb_rollback_thread_idx), 32'd1);
    check_eq("flt_pc",     bus.wb_rollback_pc, 32'h1000);
    check_eq("flt_trap",   32'(bus.wb_trap), 32'd1);
    check_eq("flt_cause",  32'(bus.wb_trap_cause), 32'(TRAP_PRIVILEGED_OP));
    settle(3);

    // Squash window: N issued, N+1 discarded, N+3 issued again.
    drive_ix(0, 32'h100, 1'b0);
    step();
    check_eq("sq_first_pc", bus.wb_rollback_pc, 32'h100);
    drive_ix(0, 32'h200, 1'b0);
    step();
    check_eq("sq_drop_en",  32'(bus.wb_rollback_en), 32'd0);
    check_eq("sq_perf",     32'(bus.wb_perf_squashed), 32'd1);
    settle(1);
    check_eq("sq_perf_one", 32'(bus.wb_perf_squashed), 32'd0);
    drive_ix(0, 32'h300, 1'b0);
    step();
    check_eq("sq_third_en", 32'(bus.wb_rollback_en), 32'd1);
    check_eq("sq_third_pc", bus.wb_rollback_pc, 32'h300);
    check_eq("sq_third_pf", 32'(bus.wb_perf_squashed), 32'd0);
    settle(3);

    // dd beats ix on another thread; ix is deferred and issues next cycle.
    drive_dd(2, 32'haaaa_0000);
    drive_ix(3, 32'hbbbb_0000, 1'b0);
    step();
    check_eq("pri_dd_thr", 32'(bus.wb_rollback_thread_idx), 32'd2);
    check_eq("pri_dd_pc",  bus.wb_rollback_pc, 32'haaaa_0000);
    settle(1);
    check_eq("pri_pd_en",  32'(bus.wb_rollback_en), 32'd1);
    check_eq("pri_pd_thr", 32'(bus.wb_rollback_thread_idx), 32'd3);
    check_eq("pri_pd_pc",  bus.wb_rollback_pc, 32'hbbbb_0000);
    settle(1);
    check_eq("pri_empty",  32'(bus.wb_rollback_en), 32'd0);
    settle(3);

    // Same-thread collision: ix dropped, nothing deferred, no squash pulse.
    drive_dd(1, 32'hcccc_0000);
    drive_ix(1, 32'hdddd_0000, 1'b0);
    step();
    check_eq("same_pc",   bus.wb_rollback_pc, 32'hcccc_0000);
    check_eq("same_perf", 32'(bus.wb_perf_squashed), 32'd0);
    settle(1);
    check_eq("same_none", 32'(bus.wb_rollback_en), 32'd0);
    settle(3);

    // Three collisions; the second dd hits the pending thread so only the third overflows.
    drive_dd(0, 32'h10);
    drive_ix(1, 32'h11, 1'b0);
    step();
    check_eq("ovf_c1", 32'(bus.wb_overflow), 32'd0);
    drive_dd(1, 32'h20);
    drive_ix(2, 32'h21, 1'b0);
    step();
    check_eq("ovf_c2_pc", bus.wb_rollback_pc, 32'h20);
    check_eq("ovf_c2",    32'(bus.wb_overflow), 32'd0);
    drive_dd(3, 32'h30);
    drive_ix(2, 32'h31, 1'b0);
    step();
    check_eq("ovf_set",   32'(bus.wb_overflow), 32'd1);
    check_eq("ovf_c3_th", 32'(bus.wb_rollback_thread_idx), 32'd3);

    // Synchronous reset clears the flag and the still-pending entry.
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("ovf_rst",    32'(bus.wb_overflow), 32'd0);
    check_eq("ovf_rst_en", 32'(bus.wb_rollback_en), 32'd0);
    settle(1);
    check_eq("rst_pend",   32'(bus.wb_rollback_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
